// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: shared constants for the decode controller slice.
//   - data / PC / instruction / register-index widths
//   - instruction field bit positions
//   - opcode values and FSM state encoding
//   - opcode classification helpers used by the controller
package decode_ctrl_pkg;

  localparam int DATA_W    = 8;
  localparam int PC_W      = 8;
  localparam int INSTR_W   = 16;
  localparam int REG_IDX_W = 3;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int SR1_MSB = 8;
  localparam int SR1_LSB = 6;
  localparam int SR2_MSB = 5;
  localparam int SR2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_AND  = 4'h3;
  localparam opcode_t OP_OR   = 4'h4;
  localparam opcode_t OP_XOR  = 4'h5;
  localparam opcode_t OP_LDI  = 4'h6;
  localparam opcode_t OP_BRZ  = 4'h7;
  localparam opcode_t OP_JMP  = 4'h8;
  localparam opcode_t OP_HALT = 4'hF;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  // Opcodes that write a register (ALU ops and LDI)
  function automatic logic is_write_op(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

  // Opcodes that update the zero flag
  function automatic logic is_alu_op(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Unassigned opcodes 9..E
  function automatic logic is_illegal_op(input opcode_t op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: fetch, register-file and status signals of decode_ctrl.
//   fetch   : instr_req_out, instr_addr_out, instr_valid_in, instr_in
//   regfile : sr1_out, sr2_out, sr1_data_in, sr2_data_in,
//             rd_out, we_reg_out, data_out, pc_latch_out
//   status  : zero_out, halted_out, illegal_out
// modport master = controller side, modport slave = memory/regfile side.
interface decode_ctrl_if;
  import decode_ctrl_pkg::*;

  logic                 instr_req_out;
  logic [PC_W-1:0]      instr_addr_out;
  logic                 instr_valid_in;
  logic [INSTR_W-1:0]   instr_in;

  logic [REG_IDX_W-1:0] sr1_out;
  logic [REG_IDX_W-1:0] sr2_out;
  logic [DATA_W-1:0]    sr1_data_in;
  logic [DATA_W-1:0]    sr2_data_in;

  logic [REG_IDX_W-1:0] rd_out;
  logic                 we_reg_out;
  logic [DATA_W-1:0]    data_out;
  logic                 pc_latch_out;

  logic                 zero_out;
  logic                 halted_out;
  logic                 illegal_out;

  modport master (
    output instr_req_out, instr_addr_out, sr1_out, sr2_out, rd_out,
           we_reg_out, data_out, pc_latch_out, zero_out, halted_out,
           illegal_out,
    input  instr_valid_in, instr_in, sr1_data_in, sr2_data_in
  );

  modport slave (
    input  instr_req_out, instr_addr_out, sr1_out, sr2_out, rd_out,
           we_reg_out, data_out, pc_latch_out, zero_out, halted_out,
           illegal_out,
    output instr_valid_in, instr_in, sr1_data_in, sr2_data_in
  );

endinterface

// File: rtl/decode_alu.sv
// decode_alu: combinational execute unit.
//   opcode : instruction opcode
//   a, b   : registered source operands (a = reg[rd] for BRZ)
//   imm8   : immediate field
//   result : ALU/LDI result; for BRZ it passes a through for the zero test
//   zero   : result == 0
module decode_alu
  import decode_ctrl_pkg::*;
(
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm8,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    result = '0;
    case (opcode)
      OP_NOP:  result = '0;
      OP_ADD:  result = a + b;   // mod 256, carry discarded
      OP_SUB:  result = a - b;   // mod 256, borrow discarded
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = imm8;
      OP_BRZ:  result = a;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: four-phase (FETCH/DECODE/EXECUTE/WRITEBACK) instruction
// controller with a terminal HALT state.
//   clka       : sole clock, rising edge
//   reset_n_in : asynchronous active-low reset
//   bus        : decode_ctrl_if.master (fetch, regfile and status signals)
// Every output is a flop or a decode of the instruction register, so there
// is no combinational path from an input to an output.
module decode_ctrl
  import decode_ctrl_pkg::*;
(
  input  logic          clka,
  input  logic          reset_n_in,
  decode_ctrl_if.master bus
);

  logic [2:0]         state, state_next;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  op_a, op_b, data_q;
  logic               req_q, we_q, pcl_q, zero_q, halted_q, illegal_q;

  opcode_t            opcode;
  logic [DATA_W-1:0]  imm8, alu_result;
  logic               alu_zero, fetch_hit;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign imm8   = ir[IMM_MSB:IMM_LSB];

  // req_q is low for the first cycle after reset, so a fetch only
  // completes once the request has actually been presented.
  assign fetch_hit = (state == ST_FETCH) && req_q && bus.instr_valid_in;

  decode_alu u_alu (
    .opcode (opcode),
    .a      (op_a),
    .b      (op_b),
    .imm8   (imm8),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:     if (fetch_hit) state_next = ST_DECODE;
      ST_DECODE:    state_next = ST_EXECUTE;
      ST_EXECUTE:   state_next = (opcode == OP_HALT) ? ST_HALT : ST_WRITEBACK;
      ST_WRITEBACK: state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clka or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      pcl_q     <= 1'b0;
      zero_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      state <= state_next;
      req_q <= (state_next == ST_FETCH);
      we_q  <= 1'b0;
      pcl_q <= 1'b0;

      if (fetch_hit) begin
        ir <= bus.instr_in;
        pc <= pc + 1'b1;
      end

      if (state == ST_DECODE) begin
        op_a <= bus.sr1_data_in;
        op_b <= bus.sr2_data_in;
      end

      // Strobes are launched on the EXECUTE->WRITEBACK edge so they are
      // high for exactly the WRITEBACK cycle.
      if (state == ST_EXECUTE) begin
        if (is_write_op(opcode)) begin
          we_q   <= 1'b1;
          data_q <= alu_result;
        end
        if (is_alu_op(opcode))
          zero_q <= alu_zero;
        if ((opcode == OP_JMP) || ((opcode == OP_BRZ) && alu_zero))
          pcl_q <= 1'b1;
        if (is_illegal_op(opcode))
          illegal_q <= 1'b1;
        if (opcode == OP_HALT)
          halted_q <= 1'b1;
      end

      // pcl_q is only high in WRITEBACK, never together with fetch_hit.
      if (pcl_q)
        pc <= imm8;
    end
  end

  assign bus.instr_req_out  = req_q;
  assign bus.instr_addr_out = pc;
  // BRZ tests reg[rd], so its rd field is routed to the source-1 port.
  assign bus.sr1_out        = (opcode == OP_BRZ) ? ir[RD_MSB:RD_LSB]
                                                 : ir[SR1_MSB:SR1_LSB];
  assign bus.sr2_out        = ir[SR2_MSB:SR2_LSB];
  assign bus.rd_out         = ir[RD_MSB:RD_LSB];
  assign bus.we_reg_out     = we_q;
  assign bus.data_out       = data_q;
  assign bus.pc_latch_out   = pcl_q;
  assign bus.zero_out       = zero_q;
  assign bus.halted_out     = halted_q;
  assign bus.illegal_out    = illegal_q;

endmodule
